// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipelined CPU front end.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;  // addi x0, x0, 0

    // Fetch sequencing: normal fetch, end-of-program drain, final halt.
    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StHalt  = 2'd2
    } fetch_state_e;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
// Priority: flush > hold > load; with no control asserted the register holds.
module ifid_reg
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  hold,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    // Register update; a bubble clears valid/instr but keeps pc/pc4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '{valid: 1'b0, pc: '0, pc4: '0, instr: NOP_INSTR};
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end else if (hold) begin
            q <= q;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, IF/ID register, stall/redirect handling and
// end-of-program drain/halt sequencing.
module if_stage
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH     = 1024,
    parameter logic [31:0] MAX_INSTR_ADDR = 32'h2c,
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter int unsigned DRAIN_CYCLES   = 4,
    localparam int unsigned ADDR_W        = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_pc_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_rdata_i,
    output logic              ifid_valid_o,
    output logic [31:0]       ifid_pc_o,
    output logic [31:0]       ifid_pc4_o,
    output logic [31:0]       ifid_instr_o,
    output logic              halted_o,
    output logic [31:0]       fetch_count_o
);

    // Counter reaches DRAIN_CYCLES + 1 at most before the halt takes effect.
    localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 2);

    fetch_state_e    state;
    logic [31:0]     pc;
    logic [CntW-1:0] drain_cnt;
    logic            halted;
    logic [31:0]     fetch_count;

    logic            in_range;
    logic [31:0]     redirect_tgt;
    logic            tgt_in_range;
    logic            ifid_load;
    logic            ifid_hold;
    logic            ifid_flush;
    ifid_t           ifid_d;
    ifid_t           ifid_q;

    assign in_range     = (pc <= MAX_INSTR_ADDR);
    // Misaligned targets are silently aligned down to a word boundary.
    assign redirect_tgt = redirect_pc_i & ~32'h3;
    assign tgt_in_range = (redirect_tgt <= MAX_INSTR_ADDR);
    assign imem_addr_o  = pc[ADDR_W+1:2];

    assign ifid_d = '{valid: 1'b1, pc: pc, pc4: pc + 32'd4, instr: imem_rdata_i};

    // Decode IF/ID control from the fetch state and hazard inputs.
    always_comb begin
        ifid_load  = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        unique case (state)
            StRun: begin
                if (redirect_valid_i) begin
                    ifid_flush = 1'b1;
                end else if (stall_i) begin
                    ifid_hold = 1'b1;
                end else if (in_range) begin
                    ifid_load = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                end
            end
            StDrain: ifid_flush = 1'b1;
            StHalt:  ifid_hold  = 1'b1;
            default: ifid_hold  = 1'b1;
        endcase
    end

    ifid_reg u_ifid_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (ifid_load),
        .hold  (ifid_hold),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    // PC, fetch counter and run/drain/halt state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StRun;
            pc          <= RESET_PC;
            drain_cnt   <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                StRun: begin
                    if (redirect_valid_i) begin
                        pc <= redirect_tgt;
                    end else if (stall_i) begin
                        pc <= pc;
                    end else if (in_range) begin
                        pc          <= pc + 32'd4;
                        fetch_count <= fetch_count + 32'd1;
                    end else begin
                        drain_cnt <= CntW'(1);
                        state     <= StDrain;
                    end
                end
                StDrain: begin
                    drain_cnt <= drain_cnt + CntW'(1);
                    if (redirect_valid_i && tgt_in_range) begin
                        // A branch older than the end of program resumes fetch.
                        pc        <= redirect_tgt;
                        drain_cnt <= '0;
                        state     <= StRun;
                    end else begin
                        if (redirect_valid_i) begin
                            pc <= redirect_tgt;
                        end
                        if (drain_cnt == CntW'(DRAIN_CYCLES)) begin
                            state  <= StHalt;
                            halted <= 1'b1;
                        end
                    end
                end
                StHalt: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= StHalt;
                end
            endcase
        end
    end

    assign ifid_valid_o  = ifid_q.valid;
    assign ifid_pc_o     = ifid_q.pc;
    assign ifid_pc4_o    = ifid_q.pc4;
    assign ifid_instr_o  = ifid_q.instr;
    assign halted_o      = halted;
    assign fetch_count_o = fetch_count;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch front end of the 5-stage pipelined CPU.
- Holds the PC and drives the instruction-memory word address. Latches the IF/ID pipeline register for decode.
- Applies the hazard unit's stall and the EX-stage branch/jump redirect.
- Detects end of program (PC past the last instruction address), drains the pipeline, then raises halted_o.

Parameters:
- IMEM_DEPTH, 1024, instruction memory depth in 32-bit words; ADDR_W = clog2(IMEM_DEPTH).
- MAX_INSTR_ADDR, 32'h2c, byte address of the last valid instruction (inclusive).
- RESET_PC, 32'h0, PC value after reset.
- DRAIN_CYCLES, 4, bubble cycles after end of program before halted_o asserts.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  load-use stall from the hazard unit; hold PC and IF/ID.
- redirect_valid_i  in  1  taken branch/jump resolved in EX.
- redirect_pc_i  in  32  redirect target byte address.
- imem_addr_o  out  ADDR_W  instruction memory word address, pc[ADDR_W+1:2]; memory read is combinational.
- imem_rdata_i  in  32  instruction word at imem_addr_o, same cycle.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- ifid_pc_o  out  32  PC of the IF/ID instruction.
- ifid_pc4_o  out  32  ifid_pc_o + 4.
- ifid_instr_o  out  32  instruction word; NOP (32'h00000013) when not valid.
- halted_o  out  1  program finished and pipeline drained.
- fetch_count_o  out  32  count of valid instructions latched into IF/ID.

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - pc = RESET_PC.
  - ifid_valid_o = 0, ifid_pc_o = 0, ifid_pc4_o = 0, ifid_instr_o = NOP.
  - state = RUN, drain counter = 0, halted_o = 0, fetch_count_o = 0.
- Release: the first rising edge after rst falls latches the instruction at RESET_PC.
- imem_addr_o is combinational from pc. Fetch-to-IF/ID latency is 1 cycle.
- in_range = (pc <= MAX_INSTR_ADDR).
- State machine, evaluated at each rising edge in priority order:
  - RUN:
    - redirect_valid_i: pc <= {redirect_pc_i[31:2],2'b00}; IF/ID <= bubble. Redirect wins over a simultaneous stall_i.
    - else stall_i: pc and IF/ID hold; fetch_count_o unchanged.
    - else in_range: IF/ID <= {1, pc, pc+4, imem_rdata_i}; pc <= pc+4; fetch_count_o += 1.
    - else (out of range): IF/ID <= bubble; pc holds; drain counter <= 1; state <= DRAIN.
  - DRAIN:
    - IF/ID stays bubble every cycle; the counter increments each cycle, including while stall_i is high.
    - redirect_valid_i with target <= MAX_INSTR_ADDR: pc <= target; counter <= 0; state <= RUN. This covers a branch older than the end of program.
    - redirect_valid_i with target out of range: pc <= target, stay in DRAIN.
    - counter == DRAIN_CYCLES: state <= HALT.
  - HALT: halted_o = 1 (registered, from state). pc and IF/ID frozen; stall_i and redirect_valid_i ignored. Only rst exits.
- A bubble is valid = 0, instr = NOP, with pc/pc4 keeping their previous values.
- PC arithmetic is modulo 2^32. A redirect_pc_i[1:0] != 0 is silently aligned down.
- imem_addr_o truncates pc to ADDR_W bits. An out-of-range pc never latches a valid instruction, so aliasing beyond IMEM_DEPTH is harmless.
- fetch_count_o wraps at 2^32.
- rst asserted mid-DRAIN or in HALT returns everything to reset values immediately.

Decomposition:
- Shared package cpu_pkg:
  - XLEN = 32.
  - NOP_INSTR = 32'h00000013.
  - fetch state enum {RUN, DRAIN, HALT}.
  - IF/ID bundle struct {valid, pc, pc4, instr}.
- One sub-module, ifid_reg: IF/ID register with load, hold (stall) and bubble (flush) controls, asynchronous reset to the bubble value.
- PC logic and the state machine live in if_stage.

Test Plan:
- Reset sequence (clk period 4 units; rst 0 for 2 units, 1 for 2 units, then 0); memory word k = 32'h1000+k. Check that in the first cycle after release, IF/ID = {1, 0x0, 0x4, 0x1000}. Then pc steps 0x4, 0x8, … and fetch_count_o increments by one per cycle.
- Stall: assert stall_i for 2 cycles at pc = 0x10. IF/ID must hold pc 0x0c, instr 0x1003; imem_addr_o holds 4; count frozen. Resume then latches 0x10 / 0x1004.
- Redirect: redirect_valid_i = 1, redirect_pc_i = 0x06, with stall_i = 1 in the same cycle. Next cycle: IF/ID bubble (valid 0, instr NOP) and pc = 0x04. Following cycle latches 0x04 / 0x1001.
- End of program, no branches: after 0x2c is latched, pc = 0x30. Expect DRAIN_CYCLES+1 bubble cycles, then halted_o = 1 with fetch_count_o = 12. Later redirects are ignored.
- Redirect in DRAIN: at drain counter = 2, redirect to 0x08. Expect a return to RUN: 0x08 latched valid and halted_o never asserted. Also test redirect to 0x40, which must stay in DRAIN and halt on schedule.
- Reset mid-DRAIN and in HALT: pulse rst asynchronously, between clock edges. Outputs must return to reset values before the next edge, and the fetch sequence restarts at RESET_PC.
